// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
package seg_pkg;

  // Scan FSM: all-off gap between digits, then one digit lit.
  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

  // Glyphs, active-high, bit0=a .. bit6=g.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Width of a digit index for a given digit count (never below 1 bit).
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Shadow-bank write / commit bus into the display scheduler.
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3:0]       wr_data;
  logic             commit;

  modport master (output wr_en, output wr_addr, output wr_data, output commit);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, input  commit);
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup; full case so no storage is implied.
  always_comb begin
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scheduler: blank gap + lit slot per digit, with a
// shadow digit bank copied into the displayed bank only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  seg_scan_ctrl_if.slave        wr_bus,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_tick,
  output logic                  commit_done
);

  localparam int IDX_W   = idx_width(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic [3:0]            shadow_q [NUM_DIGITS];
  logic [3:0]            shadow_d [NUM_DIGITS];
  logic [3:0]            active_q [NUM_DIGITS];
  logic [3:0]            active_d [NUM_DIGITS];
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  commit_done_q, commit_done_d;

  logic                  boundary;
  logic [6:0]            lit_seg;

  seg_hex_decode u_decode (
    .nibble (active_q[idx_q]),
    .seg    (lit_seg)
  );

  // Next-state logic: scan sequencing, commit tracking, banks and outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;

    if (ena) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end

    // A commit landing on the boundary cycle re-arms for the next frame.
    if (wr_bus.commit)  pending_d = 1'b1;
    else if (boundary)  pending_d = 1'b0;
    else                pending_d = pending_q;

    // Copy reads the registered shadow, so a same-cycle write is not taken.
    active_d = active_q;
    if (boundary && pending_q) active_d = shadow_q;

    shadow_d = shadow_q;
    if (wr_bus.wr_en && (32'(wr_bus.wr_addr) < NUM_DIGITS))
      shadow_d[wr_bus.wr_addr] = wr_bus.wr_data;

    seg_d         = '0;
    dig_en_d      = '0;
    if (ena && state_q == ST_SHOW) begin
      seg_d    = lit_seg;
      dig_en_d = NUM_DIGITS'(1) << idx_q;
    end
    frame_tick_d  = boundary;
    commit_done_d = boundary && pending_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      seg_q         <= '0;
      dig_en_q      <= '0;
      frame_tick_q  <= 1'b0;
      commit_done_q <= 1'b0;
      // NOTE: both digit banks are cleared on reset so a restarted display
      // shows zeros rather than stale digits; they are small flop arrays.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
      frame_tick_q  <= frame_tick_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign seg_out     = seg_q;
  assign dig_en      = dig_en_q;
  assign frame_tick  = frame_tick_q;
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2).
// Edge n counts rising edges since the last reset release; outputs are
// sampled 1ns after edge n. Digit slot k is lit for n in 6k+3 .. 6k+6 of each
// 24-edge frame, and frame_tick/commit_done are high at n = 24, 48, ...
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [6:0] seg_out;
  logic [3:0] dig_en;
  logic       frame_tick;
  logic       commit_done;

  int n     = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         n;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       tick;
    logic       done;
  } vec_t;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .PRESCALE     (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .wr_bus      (bus.slave),
    .seg_out     (seg_out),
    .dig_en      (dig_en),
    .frame_tick  (frame_tick),
    .commit_done (commit_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got dig/seg/tick/done=%h/%h/%b/%b want %h/%h/%b/%b",
               name, n, act[12:9], act[8:2], act[1], act[0],
               exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_at(input string name, input int at, input logic [3:0] dig,
                          input logic [6:0] seg, input logic tk, input logic dn);
    run_to(at);
    check(name, {dig_en, seg_out, frame_tick, commit_done}, {dig, seg, tk, dn});
  endtask

  task automatic wr(input logic [1:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  vec_t t1 [12];

  initial begin
    t1[0]  = '{1,  4'h0, 7'h00, 1'b0, 1'b0};
    t1[1]  = '{2,  4'h0, 7'h00, 1'b0, 1'b0};
    t1[2]  = '{3,  4'h1, 7'h3F, 1'b0, 1'b0};
    t1[3]  = '{6,  4'h1, 7'h3F, 1'b0, 1'b0};
    t1[4]  = '{7,  4'h0, 7'h00, 1'b0, 1'b0};
    t1[5]  = '{9,  4'h2, 7'h3F, 1'b0, 1'b0};
    t1[6]  = '{15, 4'h4, 7'h3F, 1'b0, 1'b0};
    t1[7]  = '{21, 4'h8, 7'h3F, 1'b0, 1'b0};
    t1[8]  = '{24, 4'h8, 7'h3F, 1'b1, 1'b0};
    t1[9]  = '{25, 4'h0, 7'h00, 1'b0, 1'b0};
    t1[10] = '{27, 4'h1, 7'h3F, 1'b0, 1'b0};
    t1[11] = '{48, 4'h8, 7'h3F, 1'b1, 1'b0};

    rst_n       = 1'b0;
    ena         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.commit  = 1'b0;
    tick();
    tick();
    check("reset", {dig_en, seg_out, frame_tick, commit_done}, 13'h0);
    rst_n = 1'b1;
    n = 0;

    // 1: free-running scan of an all-zero bank.
    for (int i = 0; i < 12; i++) check_at("scan", t1[i].n, t1[i].dig, t1[i].seg, t1[i].tick, t1[i].done);

    // 2: shadow writes stay hidden until a commit reaches a boundary.
    wr(2'd3, 4'hF);
    wr(2'd2, 4'hA);
    wr(2'd1, 4'h8);
    check_at("no_commit_d0", 51, 4'h1, 7'h3F, 1'b0, 1'b0);
    wr(2'd0, 4'h1);
    check_at("no_commit_edge", 72, 4'h8, 7'h3F, 1'b1, 1'b0);
    run_to(74);
    do_commit();
    check_at("commit_edge", 96, 4'h8, 7'h3F, 1'b1, 1'b1);
    check_at("new_d0", 99, 4'h1, 7'h06, 1'b0, 1'b0);
    check_at("new_d1", 105, 4'h2, 7'h7F, 1'b0, 1'b0);
    check_at("new_d2", 111, 4'h4, 7'h77, 1'b0, 1'b0);
    check_at("new_d3", 117, 4'h8, 7'h71, 1'b0, 1'b0);
    check_at("pend_clear", 120, 4'h8, 7'h71, 1'b1, 1'b0);

    // 3: commit sampled exactly on the boundary edge is deferred.
    run_to(124);
    wr(2'd0, 4'h5);
    run_to(143);
    do_commit();
    check_at("late_commit", 144, 4'h8, 7'h71, 1'b1, 1'b0);
    check_at("late_d0_old", 147, 4'h1, 7'h06, 1'b0, 1'b0);

    // 6: write to digit 2 on the same edge as the copy.
    run_to(167);
    wr(2'd2, 4'h3);
    check_at("deferred_done", 168, 4'h8, 7'h71, 1'b1, 1'b1);
    check_at("copy_d0", 171, 4'h1, 7'h6D, 1'b0, 1'b0);
    check_at("race_d2_old", 183, 4'h4, 7'h77, 1'b0, 1'b0);
    run_to(179);
    do_commit();
    check_at("race_commit", 192, 4'h8, 7'h71, 1'b1, 1'b1);

    // 4: ten-cycle freeze in the middle of digit 0's lit slot.
    check_at("pre_freeze", 195, 4'h1, 7'h6D, 1'b0, 1'b0);
    ena = 1'b0;
    check_at("freeze_first", 196, 4'h0, 7'h00, 1'b0, 1'b0);
    check_at("freeze_last", 205, 4'h0, 7'h00, 1'b0, 1'b0);
    ena = 1'b1;
    check_at("resume", 206, 4'h1, 7'h6D, 1'b0, 1'b0);
    check_at("resume_end", 208, 4'h1, 7'h6D, 1'b0, 1'b0);
    check_at("resume_blank", 209, 4'h0, 7'h00, 1'b0, 1'b0);
    check_at("old_edge_gone", 216, 4'h0, 7'h00, 1'b0, 1'b0);
    check_at("race_d2_new", 217, 4'h4, 7'h4F, 1'b0, 1'b0);
    check_at("shifted_edge", 226, 4'h8, 7'h71, 1'b1, 1'b0);

    // 5: reset mid-frame with a commit pending.
    run_to(228);
    wr(2'd0, 4'h7);
    do_commit();
    run_to(234);
    rst_n = 1'b0;
    tick();
    check("mid_reset", {dig_en, seg_out, frame_tick, commit_done}, 13'h0);
    rst_n = 1'b1;
    n = 0;
    check_at("rst_blank", 1, 4'h0, 7'h00, 1'b0, 1'b0);
    check_at("rst_d0", 3, 4'h1, 7'h3F, 1'b0, 1'b0);
    check_at("rst_no_pend", 24, 4'h8, 7'h3F, 1'b1, 1'b0);
    run_to(29);
    do_commit();
    check_at("rst_commit", 48, 4'h8, 7'h3F, 1'b1, 1'b1);
    check_at("rst_shadow0", 51, 4'h1, 7'h3F, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
